shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_sequencer_if.sv | 19 +
 rtl/shift_counter.sv | 25 ++
 rtl/shift_step.sv | 18 +
 rtl/shift_sequencer.sv | 69 ++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer: op encoding, FSM states and default width.
package shift_pkg;

   localparam int DEFAULT_W = 32;

   typedef enum logic [1:0] {
      SHR  = 2'b00,
      SHRA = 2'b01,
      SHL  = 2'b10,
      SHC  = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } seq_state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Control/status bundle between a host and the shift sequencer (the data bus stays a plain inout).
interface shift_sequencer_if import shift_pkg::*; #(
   parameter int W = DEFAULT_W
);
   logic         ld_a;
   logic         start;
   logic         out_en;
   shift_op_e    op;
   logic         n;
   logic         decr;
   logic         busy;
   logic         done;
   logic [W-1:0] tb_a;

   modport slave  (input  ld_a, start, out_en, op, n,
                   output decr, busy, done, tb_a);
   modport master (output ld_a, start, out_en, op,
                   input  n, decr, busy, done, tb_a);
endinterface

// File: rtl/shift_counter.sv
// Downstream shift counter: loads a count from the bus, counts down on decr, flags zero on n.
module shift_counter #(
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] i_count,
   input  logic          i_load,
   input  logic          decr,
   output logic          n
);
   logic [CW-1:0] r_cnt;

   assign n = (r_cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_count;
      end else if (decr && !n) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end
endmodule

// File: rtl/shift_step.sv
// Single-bit shift of the operand according to the latched shift kind.
module shift_step import shift_pkg::*; #(
   parameter int w = DEFAULT_W
) (
   input  logic [w-1:0] i_a,
   input  shift_op_e    i_op,
   output logic [w-1:0] o_a
);
   always_comb begin
      o_a = i_a;
      case (i_op)
         SHR:     o_a = {1'b0, i_a[w-1:1]};
         SHRA:    o_a = {i_a[w-1], i_a[w-1:1]};
         SHL:     o_a = {i_a[w-2:0], 1'b0};
         default: o_a = {i_a[w-2:0], i_a[w-1]};
      endcase
   end
endmodule

// File: rtl/shift_sequencer.sv
// Operand register A with a three-state sequencer that shifts A once per cycle until the counter reports zero.
module shift_sequencer import shift_pkg::*; #(
   parameter int w = DEFAULT_W
) (
   input  logic         clk,
   input  logic         rst,
   inout  wire  [w-1:0] bus,
   shift_sequencer_if.slave sif
);
   seq_state_e   r_state;
   shift_op_e    r_op;
   logic [w-1:0] r_a;
   logic         r_busy;
   logic         r_done;
   logic [w-1:0] w_step;
   logic         w_drive;

   shift_step #(.w(w)) u_step (
      .i_a  (r_a),
      .i_op (r_op),
      .o_a  (w_step)
   );

   // Host controls only matter in IDLE, so the bus is released for the whole sequence.
   assign w_drive   = (r_state == IDLE) && sif.out_en;
   assign bus       = w_drive ? r_a : 'z;
   assign sif.decr  = (r_state == SHIFT) && !sif.n;
   assign sif.busy  = r_busy;
   assign sif.done  = r_done;
   assign sif.tb_a  = r_a;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_op    <= SHR;
         r_a     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (sif.ld_a) r_a <= bus;
               if (sif.start) begin
                  r_op    <= sif.op;
                  r_state <= SHIFT;
                  r_busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (!sif.n) begin
                  r_a <= w_step;
               end else begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule
